// File: rtl/lsq_pkg.sv
// Shared LSQ allocation types and slot-count helpers.
// Helpers take up to MAX_DISP slots; callers zero-extend narrower groups.
package lsq_pkg;

  localparam int MAX_DISP       = 8;
  localparam int STQ_DEPTH_DFLT = 16;
  localparam int LDQ_DEPTH_DFLT = 16;

  typedef struct packed {
    logic valid;
    logic is_st;
    logic is_ld;
  } LSQ_ALLOC_REQ;

  typedef logic [$clog2(STQ_DEPTH_DFLT):0] stq_ptr_t;
  typedef logic [$clog2(LDQ_DEPTH_DFLT):0] ldq_ptr_t;

  function automatic logic [3:0] popcount(input logic [MAX_DISP-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int j = 0; j < MAX_DISP; j++) c = c + 4'(v[j]);
    return c;
  endfunction

  // Number of set bits strictly below position n.
  function automatic logic [3:0] prefix_cnt(input logic [MAX_DISP-1:0] v, input int n);
    logic [3:0] c;
    c = '0;
    for (int j = 0; j < MAX_DISP; j++) begin
      if (j < n) c = c + 4'(v[j]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lsq_ptr_ring.sv
// One {wrap,idx} head/tail ring: heads and tails advance by counts, tail reloads on flush.
// Registered pointers, count = tail - head combinationally; no backpressure of its own.
module lsq_ptr_ring #(
  parameter int DEPTH = 16,
  parameter int ADV_W = 3,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADV_W-1:0] head_adv,
  input  logic [ADV_W-1:0] tail_adv,
  input  logic             flush_load,
  input  logic [PW-1:0]    flush_val,
  output logic [PW-1:0]    head,
  output logic [PW-1:0]    tail,
  output logic [PW-1:0]    count,
  output logic [PW-1:0]    head_nxt
);

  assign head_nxt = head + PW'(head_adv);
  assign count    = tail - head;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= flush_load ? flush_val : tail + PW'(tail_adv);
    end
  end

endmodule

// File: rtl/lsq_alloc.sv
// LSQ allocation front end: STQ/LDQ tags and older-store snapshots, same-cycle combinational.
// Free space from registered counts only; LSQ_ALLOC_PARTIAL_EN accepts the fitting prefix, else all-or-nothing.
module lsq_alloc
  import lsq_pkg::*;
#(
  parameter int DISP_WIDTH = 4,
  parameter int STQ_DEPTH  = 16,
  parameter int LDQ_DEPTH  = 16,
  localparam int STQ_W = $clog2(STQ_DEPTH),
  localparam int LDQ_W = $clog2(LDQ_DEPTH),
  localparam int CNT_W = $clog2(DISP_WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [DISP_WIDTH-1:0]                 disp_valid,
  input  logic [DISP_WIDTH-1:0]                 disp_is_st,
  input  logic [DISP_WIDTH-1:0]                 disp_is_ld,
  output logic [DISP_WIDTH-1:0]                 disp_accept,
  output logic                                  disp_ready,
  output logic [DISP_WIDTH-1:0][STQ_W-1:0]      disp_stq_tag,
  output logic [DISP_WIDTH-1:0][LDQ_W-1:0]      disp_ldq_tag,
  output logic [DISP_WIDTH-1:0][STQ_DEPTH-1:0]  disp_ld_st_mask,
  output logic [DISP_WIDTH-1:0][STQ_W-1:0]      disp_ld_st_yng,
  output logic [DISP_WIDTH-1:0]                 disp_ld_st_none,
  input  logic [CNT_W-1:0]                      st_commit_cnt,
  input  logic                                  st_drain_cnt,
  input  logic [CNT_W-1:0]                      ld_retire_cnt,
  output logic [STQ_W:0]                        stq_count,
  output logic [LDQ_W:0]                        ldq_count,
  output logic [STQ_DEPTH-1:0]                  stq_alloc_mask
);

  localparam int SP = STQ_W + 1;
  localparam int LP = LDQ_W + 1;

  LSQ_ALLOC_REQ                          req [DISP_WIDTH];
  logic [DISP_WIDTH-1:0]                 st_req, ld_req;
  logic [DISP_WIDTH:0][CNT_W-1:0]        st_pre, ld_pre;
  logic [DISP_WIDTH:0][STQ_DEPTH-1:0]    mask_pre;
  logic [SP-1:0] stq_head, stq_tail, stq_head_nxt, stq_cmt, stq_cmt_nxt, stq_free;
  logic [LP-1:0] ldq_head, ldq_tail, ldq_head_nxt, ldq_free;
  logic [DISP_WIDTH-1:0] accept_raw;
  logic                  ready_raw;
  logic [CNT_W-1:0]      acc_st, acc_ld;

  for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_req
    assign req[i]    = '{valid: disp_valid[i], is_st: disp_is_st[i], is_ld: disp_is_ld[i]};
    assign st_req[i] = req[i].valid & req[i].is_st;
    assign ld_req[i] = req[i].valid & req[i].is_ld;
  end

  // Entry i holds the count of slots below i; entry DISP_WIDTH is the group total.
  for (genvar i = 0; i <= DISP_WIDTH; i++) begin : g_pre
    assign st_pre[i] = CNT_W'(prefix_cnt(MAX_DISP'(st_req), i));
    assign ld_pre[i] = CNT_W'(prefix_cnt(MAX_DISP'(ld_req), i));
  end

  assign stq_free  = SP'(STQ_DEPTH) - stq_count;
  assign ldq_free  = LP'(LDQ_DEPTH) - ldq_count;
  assign ready_raw = (SP'(st_pre[DISP_WIDTH]) <= stq_free) &&
                     (LP'(ld_pre[DISP_WIDTH]) <= ldq_free);

`ifdef LSQ_ALLOC_PARTIAL_EN
  logic [DISP_WIDTH-1:0] fit;
  for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_fit
    assign fit[i] = (SP'(st_pre[i+1]) <= stq_free) && (LP'(ld_pre[i+1]) <= ldq_free);
  end
  assign accept_raw = disp_valid & fit;
`else
  assign accept_raw = disp_valid & {DISP_WIDTH{ready_raw}};
`endif

  assign disp_accept = flush ? '0 : accept_raw;
  assign disp_ready  = ready_raw & ~flush;
  assign acc_st      = CNT_W'(popcount(MAX_DISP'(disp_accept & st_req)));
  assign acc_ld      = CNT_W'(popcount(MAX_DISP'(disp_accept & ld_req)));

  for (genvar e = 0; e < STQ_DEPTH; e++) begin : g_alloc
    logic [STQ_W-1:0] off;
    assign off               = STQ_W'(e) - stq_head[STQ_W-1:0];
    assign stq_alloc_mask[e] = SP'(off) < stq_count;
  end

  // Each load sees the allocated ring plus the stores ahead of it in this group.
  assign mask_pre[0] = stq_alloc_mask;
  for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_slot
    assign disp_stq_tag[i]    = stq_tail[STQ_W-1:0] + STQ_W'(st_pre[i]);
    assign disp_ldq_tag[i]    = ldq_tail[LDQ_W-1:0] + LDQ_W'(ld_pre[i]);
    assign mask_pre[i+1]      = mask_pre[i] |
                                (st_req[i] ? (STQ_DEPTH'(1) << disp_stq_tag[i]) : '0);
    assign disp_ld_st_mask[i] = mask_pre[i];
    assign disp_ld_st_none[i] = (stq_count == '0) && (st_pre[i] == '0);
    assign disp_ld_st_yng[i]  = disp_ld_st_none[i] ? '0 :
                                stq_tail[STQ_W-1:0] - STQ_W'(1) + STQ_W'(st_pre[i]);
  end

  assign stq_cmt_nxt = stq_cmt + SP'(st_commit_cnt);

  always_ff @(posedge clk) begin
    if (rst) stq_cmt <= '0;
    else     stq_cmt <= stq_cmt_nxt;
  end

  lsq_ptr_ring #(.DEPTH(STQ_DEPTH), .ADV_W(CNT_W)) u_stq_ring (
    .clk        (clk),
    .rst        (rst),
    .head_adv   (CNT_W'(st_drain_cnt)),
    .tail_adv   (acc_st),
    .flush_load (flush),
    .flush_val  (stq_cmt_nxt),
    .head       (stq_head),
    .tail       (stq_tail),
    .count      (stq_count),
    .head_nxt   (stq_head_nxt)
  );

  lsq_ptr_ring #(.DEPTH(LDQ_DEPTH), .ADV_W(CNT_W)) u_ldq_ring (
    .clk        (clk),
    .rst        (rst),
    .head_adv   (ld_retire_cnt),
    .tail_adv   (acc_ld),
    .flush_load (flush),
    .flush_val  (ldq_head_nxt),
    .head       (ldq_head),
    .tail       (ldq_tail),
    .count      (ldq_count),
    .head_nxt   (ldq_head_nxt)
  );

  a_stq_order: assert property (@(posedge clk) disable iff (rst)
    (SP'(stq_cmt - stq_head) <= stq_count) && (stq_count <= SP'(STQ_DEPTH)));
  a_stq_adv: assert property (@(posedge clk) disable iff (rst)
    SP'(stq_cmt_nxt - stq_head_nxt) <= SP'(stq_tail - stq_head_nxt));
  a_ldq_adv: assert property (@(posedge clk) disable iff (rst)
    (LP'(ldq_head_nxt - ldq_head) <= ldq_count) && (LP'(ldq_tail - ldq_head) <= LP'(LDQ_DEPTH)));

endmodule

// File: tb/tb_lsq_alloc.sv
// Directed plus random bench for lsq_alloc against an unbounded-counter queue model.
module tb_lsq_alloc;

  localparam int DW = 4;
  localparam int SD = 16;
  localparam int LD = 16;
  localparam int CW = 3;

  logic                   clk = 1'b0;
  logic                   rst, flush;
  logic [DW-1:0]          disp_valid, disp_is_st, disp_is_ld, disp_accept;
  logic                   disp_ready;
  logic [DW-1:0][3:0]     disp_stq_tag, disp_ldq_tag, disp_ld_st_yng;
  logic [DW-1:0][SD-1:0]  disp_ld_st_mask;
  logic [DW-1:0]          disp_ld_st_none;
  logic [CW-1:0]          st_commit_cnt, ld_retire_cnt;
  logic                   st_drain_cnt;
  logic [4:0]             stq_count, ldq_count;
  logic [SD-1:0]          stq_alloc_mask;

  int errors = 0;
  int checks = 0;
  // Model pointers are plain ever-increasing counters; tags are value mod depth.
  int m_sh = 0, m_sc = 0, m_st = 0, m_lh = 0, m_lt = 0;

  lsq_alloc #(.DISP_WIDTH(DW), .STQ_DEPTH(SD), .LDQ_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_is_st(disp_is_st), .disp_is_ld(disp_is_ld),
    .disp_accept(disp_accept), .disp_ready(disp_ready),
    .disp_stq_tag(disp_stq_tag), .disp_ldq_tag(disp_ldq_tag),
    .disp_ld_st_mask(disp_ld_st_mask), .disp_ld_st_yng(disp_ld_st_yng),
    .disp_ld_st_none(disp_ld_st_none),
    .st_commit_cnt(st_commit_cnt), .st_drain_cnt(st_drain_cnt), .ld_retire_cnt(ld_retire_cnt),
    .stq_count(stq_count), .ldq_count(ldq_count), .stq_alloc_mask(stq_alloc_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SD-1:0] range_mask(input int lo, input int hi);
    logic [SD-1:0] m;
    m = '0;
    for (int k = lo; k < hi; k++) m[k % SD] = 1'b1;
    return m;
  endfunction

  task automatic idle();
    flush = 0; disp_valid = '0; disp_is_st = '0; disp_is_ld = '0;
    st_commit_cnt = '0; st_drain_cnt = 0; ld_retire_cnt = '0;
  endtask

  task automatic group(input logic [DW-1:0] v, input logic [DW-1:0] s, input logic [DW-1:0] l);
    disp_valid = v; disp_is_st = s; disp_is_ld = l;
  endtask

  // Check all outputs against the model, clock once, advance the model.
  task automatic cycle();
    int sfree, lfree, sb, lb, sn, ln, ts, tl, as, al;
    logic [DW-1:0] exp_acc;
    logic exp_rdy, none;
    exp_acc = '0;
    #1;
    if (!rst) begin
      sfree = SD - (m_st - m_sh);
      lfree = LD - (m_lt - m_lh);
      ts = 0; tl = 0;
      for (int i = 0; i < DW; i++) begin
        if (disp_valid[i] && disp_is_st[i]) ts++;
        if (disp_valid[i] && disp_is_ld[i]) tl++;
      end
      exp_rdy = !flush && ts <= sfree && tl <= lfree;
      sb = 0; lb = 0;
      for (int i = 0; i < DW; i++) begin
        sn = sb + int'(disp_valid[i] && disp_is_st[i]);
        ln = lb + int'(disp_valid[i] && disp_is_ld[i]);
`ifdef LSQ_ALLOC_PARTIAL_EN
        exp_acc[i] = disp_valid[i] && !flush && sn <= sfree && ln <= lfree;
`else
        exp_acc[i] = disp_valid[i] && exp_rdy;
`endif
        if (disp_valid[i] && disp_is_st[i])
          chk($sformatf("stq_tag%0d", i), disp_stq_tag[i], (m_st + sb) % SD);
        if (disp_valid[i] && disp_is_ld[i]) begin
          none = (m_st == m_sh) && sb == 0;
          chk($sformatf("ldq_tag%0d", i), disp_ldq_tag[i], (m_lt + lb) % LD);
          chk($sformatf("ld_mask%0d", i), disp_ld_st_mask[i], range_mask(m_sh, m_st + sb));
          chk($sformatf("ld_none%0d", i), disp_ld_st_none[i], none);
          chk($sformatf("ld_yng%0d", i), disp_ld_st_yng[i], none ? 0 : (m_st + sb - 1) % SD);
        end
        sb = sn; lb = ln;
      end
      chk("accept", disp_accept, exp_acc);
      chk("ready", disp_ready, exp_rdy);
      chk("stq_count", stq_count, m_st - m_sh);
      chk("ldq_count", ldq_count, m_lt - m_lh);
      chk("alloc_mask", stq_alloc_mask, range_mask(m_sh, m_st));
    end
    @(posedge clk);
    if (rst) begin
      m_sh = 0; m_sc = 0; m_st = 0; m_lh = 0; m_lt = 0;
    end else begin
      as = 0; al = 0;
      for (int i = 0; i < DW; i++) begin
        if (exp_acc[i] && disp_is_st[i]) as++;
        if (exp_acc[i] && disp_is_ld[i]) al++;
      end
      m_sh += int'(st_drain_cnt);
      m_sc += int'(st_commit_cnt);
      m_lh += int'(ld_retire_cnt);
      if (flush) begin
        m_st = m_sc;
        m_lt = m_lh;
      end else begin
        m_st += as;
        m_lt += al;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    logic [DW-1:0] v, s, l, exp_d;
    int cmax, rmax, old_head;
    idle();
    rst = 1;
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    chk("rst_stq_count", stq_count, 0);
    chk("rst_ldq_count", ldq_count, 0);
    chk("rst_alloc_mask", stq_alloc_mask, 0);
    chk("rst_ready", disp_ready, 1);

    // {st,ld,ld,st}
    group(4'b1111, 4'b1001, 4'b0110);
    #1;
    chk("A_st3_tag", disp_stq_tag[3], 1);
    chk("A_ld1_tag", disp_ldq_tag[1], 0);
    chk("A_ld2_tag", disp_ldq_tag[2], 1);
    chk("A_ld1_mask", disp_ld_st_mask[1], 16'h0001);
    chk("A_ld2_yng", disp_ld_st_yng[2], 0);
    cycle();
    idle();
    #1;
    chk("A_stq_count", stq_count, 2);
    chk("A_ldq_count", ldq_count, 2);

    // First-ever group {ld,st,ld}
    do_reset();
    group(4'b0111, 4'b0010, 4'b0101);
    #1;
    chk("B_ld0_none", disp_ld_st_none[0], 1);
    chk("B_ld2_mask", disp_ld_st_mask[2], 16'h0001);
    chk("B_ld2_none", disp_ld_st_none[2], 0);
    cycle();

    // Walk STQ head and tail to 14, then dispatch across the wrap
    do_reset();
    for (int k = 0; k < 3; k++) begin
      group(4'b1111, 4'b1111, 4'b0000);
      cycle();
    end
    group(4'b0011, 4'b0011, 4'b0000);
    cycle();
    idle();
    for (int k = 0; k < 4; k++) begin
      st_commit_cnt = (k == 3) ? 3'd2 : 3'd4;
      cycle();
    end
    st_commit_cnt = 0;
    st_drain_cnt = 1;
    for (int k = 0; k < 14; k++) cycle();
    idle();
    group(4'b1111, 4'b0111, 4'b1000);
    #1;
    chk("C_tag0", disp_stq_tag[0], 14);
    chk("C_tag2", disp_stq_tag[2], 0);
    chk("C_ld3_mask", disp_ld_st_mask[3], 16'hC001);
    chk("C_ld3_yng", disp_ld_st_yng[3], 0);
    cycle();

    // Fill STQ to 15, then offer two stores
    for (int k = 0; k < 3; k++) begin
      group(4'b1111, 4'b1111, 4'b0000);
      cycle();
    end
`ifdef LSQ_ALLOC_PARTIAL_EN
    exp_d = 4'b0001;
`else
    exp_d = 4'b0000;
`endif
    group(4'b0011, 4'b0011, 4'b0000);
    #1;
    chk("D_accept", disp_accept, exp_d);
    chk("D_ready", disp_ready, 0);
    cycle();
    idle();
    #1;
    chk("D_stq_count", stq_count, 15 + int'(exp_d[0]));

    // Full STQ: same-cycle drain gives no space until next cycle
    group(4'b0001, 4'b0001, 4'b0000);
    cycle();
    idle();
    st_commit_cnt = 4;
    cycle();
    idle();
    old_head = m_sh % SD;
    group(4'b0001, 4'b0001, 4'b0000);
    st_drain_cnt = 1;
    #1;
    chk("E_full_accept", disp_accept, 0);
    cycle();
    st_drain_cnt = 0;
    #1;
    chk("E_next_accept", disp_accept, 4'b0001);
    chk("E_next_tag", disp_stq_tag[0], old_head);
    cycle();

    // Flush with commit=3, tail=7
    do_reset();
    group(4'b1111, 4'b1111, 4'b0000);
    cycle();
    group(4'b1111, 4'b0111, 4'b1000);
    cycle();
    idle();
    st_commit_cnt = 3;
    cycle();
    group(4'b1111, 4'b1010, 4'b0101);
    flush = 1; st_commit_cnt = 1; st_drain_cnt = 1;
    #1;
    chk("F_accept", disp_accept, 0);
    cycle();
    idle();
    #1;
    chk("F_stq_count", stq_count, 3);
    chk("F_ldq_count", ldq_count, 0);
    chk("F_alloc_mask", stq_alloc_mask, 16'h000E);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      v = DW'($urandom);
      s = DW'($urandom);
      l = DW'($urandom) & ~s;
      group(v, s, l);
      cmax = m_st - m_sc; if (cmax > DW) cmax = DW;
      rmax = m_lt - m_lh; if (rmax > DW) rmax = DW;
      st_commit_cnt = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(0, cmax)) : '0;
      ld_retire_cnt = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(0, rmax)) : '0;
      st_drain_cnt  = (m_sc > m_sh) && ($urandom_range(0, 1) == 1);
      flush         = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      cycle();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
